stream_arbiter_wrr: RTL and testbench

//  Weighted round-robin arbiter: N_INP valid/ready input streams onto one output stream.
//  - Each grant holds an input for up to weight_i[n] beats (PKT_MODE=0) or packets (PKT_MODE=1).
//  - A held grant never breaks a packet. Output is stable until its handshake.
//  - Placed in front of shared interconnect ports that need bandwidth shares, not equal turns.

---
 rtl/stream_arbiter_wrr_if.sv | 25 ++
 rtl/stream_arbiter_wrr.sv | 133 +++++++++++++
 tb/tb_stream_arbiter_wrr.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_arbiter_wrr_if.sv
// Stream bundle for the weighted round-robin arbiter: N_INP valid/ready inputs, one output.
interface stream_arbiter_wrr_if #(
  parameter int  N_INP  = 2,
  parameter type DATA_T = logic
);
  DATA_T                      inp_data_i [N_INP];
  logic [N_INP-1:0]           inp_last_i;
  logic [N_INP-1:0]           inp_valid_i;
  logic [N_INP-1:0]           inp_ready_o;
  DATA_T                      oup_data_o;
  logic                       oup_last_o;
  logic [$clog2(N_INP)-1:0]   oup_idx_o;
  logic                       oup_valid_o;
  logic                       oup_ready_i;

  // slave: the arbiter's view; master: the surrounding sources and sink
  modport slave (
    input  inp_data_i, inp_last_i, inp_valid_i, oup_ready_i,
    output inp_ready_o, oup_data_o, oup_last_o, oup_idx_o, oup_valid_o
  );
  modport master (
    output inp_data_i, inp_last_i, inp_valid_i, oup_ready_i,
    input  inp_ready_o, oup_data_o, oup_last_o, oup_idx_o, oup_valid_o
  );
endinterface

// File: rtl/stream_arbiter_wrr.sv
// Weighted round-robin stream arbiter: a grant holds an input for up to weight_i[n]
// beats (PKT_MODE=0) or whole packets (PKT_MODE=1); zero-latency selection in IDLE.
module stream_arbiter_wrr #(
  parameter type DATA_T   = logic,
  parameter int  N_INP    = 2,
  parameter int  WEIGHT_W = 4,
  parameter int  PKT_MODE = 0,
  localparam int IDX_W    = $clog2(N_INP)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [N_INP-1:0][WEIGHT_W-1:0] weight_i,
  stream_arbiter_wrr_if.slave            bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d, rr_q, rr_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic                 mid_pkt_q, mid_pkt_d;

  logic [N_INP-1:0]     elig;
  logic [IDX_W-1:0]     first_idx, sel;
  logic                 found, active, oup_valid, hs, sel_last, unit;
  DATA_T                sel_data;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_INP - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  always_comb begin
    for (int n = 0; n < N_INP; n++) elig[n] = bus.inp_valid_i[n] && (weight_i[n] != '0);
  end

  // Scan offsets from high to low so the candidate closest to rr_q is written last.
  always_comb begin
    int n;
    n         = 0;
    found     = 1'b0;
    first_idx = rr_q;
    for (int k = N_INP - 1; k >= 0; k--) begin
      n = int'(rr_q) + k;
      if (n >= N_INP) n = n - N_INP;
      if (elig[n]) begin
        found     = 1'b1;
        first_idx = IDX_W'(n);
      end
    end
  end

  always_comb begin
    active    = !rst_i && !flush_i;
    sel       = (state_q == GRANT) ? gnt_q : first_idx;
    oup_valid = active && ((state_q == GRANT) ? bus.inp_valid_i[gnt_q] : found);
    sel_data  = bus.inp_data_i[sel];
    sel_last  = (PKT_MODE != 0) && bus.inp_last_i[sel];
    hs        = oup_valid && bus.oup_ready_i;
    unit      = hs && ((PKT_MODE == 0) || sel_last);

    bus.inp_ready_o = '0;
    if (active && ((state_q == GRANT) || found)) bus.inp_ready_o[sel] = bus.oup_ready_i;
    bus.oup_valid_o = oup_valid;
    bus.oup_idx_o   = sel;
    bus.oup_data_o  = sel_data;
    bus.oup_last_o  = sel_last;
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    credit_d  = credit_q;
    rr_d      = rr_q;
    mid_pkt_d = mid_pkt_q;
    if (flush_i) begin
      state_d   = IDLE;
      gnt_d     = '0;
      credit_d  = '0;
      rr_d      = '0;
      mid_pkt_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            // A single-credit grant spent on its first beat never enters GRANT.
            if (unit && (weight_i[sel] == WEIGHT_W'(1))) begin
              rr_d = wrap_inc(sel);
            end else begin
              state_d   = GRANT;
              gnt_d     = sel;
              credit_d  = weight_i[sel] - WEIGHT_W'(unit);
              mid_pkt_d = (PKT_MODE != 0) && hs && !sel_last;
            end
          end
        end
        GRANT: begin
          if (hs) begin
            mid_pkt_d = (PKT_MODE != 0) && !sel_last;
            if (unit) credit_d = credit_q - WEIGHT_W'(1);
            if (unit && (credit_q == WEIGHT_W'(1))) begin
              state_d   = IDLE;
              rr_d      = wrap_inc(gnt_q);
              mid_pkt_d = 1'b0;
            end
          end else if (!bus.inp_valid_i[gnt_q] && !mid_pkt_q) begin
            state_d  = IDLE;
            rr_d     = wrap_inc(gnt_q);
            credit_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      credit_q  <= '0;
      rr_q      <= '0;
      mid_pkt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      credit_q  <= credit_d;
      rr_q      <= rr_d;
      mid_pkt_q <= mid_pkt_d;
    end
  end

endmodule

// File: tb/tb_stream_arbiter_wrr.sv
// Bench for stream_arbiter_wrr: beat-mode (d=0) and packet-mode (d=1) instances, 3 inputs each.
module tb_stream_arbiter_wrr;
  localparam int N  = 3;
  localparam int WW = 4;
  localparam int NV = 17;
  typedef logic [7:0] data_t;

  typedef struct packed {
    logic [2:0] vld;
    logic       ordy;
    logic       ev;
    logic [1:0] eidx;
    logic [2:0] erdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]                  flush, ordy;
  logic [1:0][N-1:0][WW-1:0]   wgt;
  logic [1:0][N-1:0]           vld, lst;
  data_t                       dat [2][N];
  logic [1:0]                  o_valid, o_last;
  logic [1:0][1:0]             o_idx;
  data_t                       o_data [2];
  logic [1:0][N-1:0]           i_rdy;

  // snapshots taken at the falling edge
  logic [1:0]                  s_valid;
  logic [1:0][1:0]             s_idx;
  data_t                       s_data [2];
  logic [1:0][N-1:0]           s_rdy;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    stream_arbiter_wrr_if #(.N_INP(N), .DATA_T(data_t)) bus ();
    stream_arbiter_wrr #(.DATA_T(data_t), .N_INP(N), .WEIGHT_W(WW), .PKT_MODE(d)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush[d]), .weight_i(wgt[d]), .bus(bus)
    );
    assign bus.inp_valid_i = vld[d];
    assign bus.inp_last_i  = lst[d];
    assign bus.oup_ready_i = ordy[d];
    for (genvar n = 0; n < N; n++) begin : g_in
      assign bus.inp_data_i[n] = dat[d][n];
    end
    assign o_valid[d] = bus.oup_valid_o;
    assign o_last[d]  = bus.oup_last_o;
    assign o_idx[d]   = bus.oup_idx_o;
    assign o_data[d]  = bus.oup_data_o;
    assign i_rdy[d]   = bus.inp_ready_o;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an owner index (-1 = free) with remaining credit, a search pointer and
  // a mid-packet flag, advanced once per clock from the rules of the arbiter.
  int m_owner [2], m_left [2], m_ptr [2];
  bit m_inpkt [2];
  bit e_valid [2], e_hs [2];
  int e_idx [2];

  task automatic model_check(input int d);
    int s;
    logic [N-1:0] er;
    s  = -1;
    er = '0;
    if (flush[d]) begin
      e_valid[d] = 1'b0;
      e_hs[d]    = 1'b0;
      chk($sformatf("flush valid d%0d", d), 32'(o_valid[d]), 32'd0);
      chk($sformatf("flush ready d%0d", d), 32'(i_rdy[d]), 32'd0);
      return;
    end
    if (m_owner[d] < 0) begin
      for (int k = 0; k < N; k++) begin
        int n;
        n = (m_ptr[d] + k) % N;
        if (s < 0 && vld[d][n] && wgt[d][n] != '0) s = n;
      end
      e_valid[d] = (s >= 0);
      e_idx[d]   = (s >= 0) ? s : m_ptr[d];
    end else begin
      e_idx[d]   = m_owner[d];
      e_valid[d] = vld[d][m_owner[d]];
    end
    if ((m_owner[d] >= 0 || s >= 0) && ordy[d]) er[e_idx[d]] = 1'b1;
    e_hs[d] = e_valid[d] && ordy[d];
    chk($sformatf("model valid d%0d", d), 32'(o_valid[d]), 32'(e_valid[d]));
    chk($sformatf("model idx d%0d", d), 32'(o_idx[d]), 32'(e_idx[d]));
    chk($sformatf("model ready d%0d", d), 32'(i_rdy[d]), 32'(er));
    if (e_valid[d]) begin
      chk($sformatf("model data d%0d", d), 32'(o_data[d]), 32'(dat[d][e_idx[d]]));
      chk($sformatf("model last d%0d", d), 32'(o_last[d]), (d == 1) ? 32'(lst[d][e_idx[d]]) : 32'd0);
    end
  endtask

  task automatic model_update(input int d);
    int o;
    if (flush[d]) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_inpkt[d] = 1'b0;
      return;
    end
    if (m_owner[d] < 0 && e_valid[d]) begin
      m_owner[d] = e_idx[d];
      m_left[d]  = int'(wgt[d][e_idx[d]]);
      m_inpkt[d] = 1'b0;
    end
    o = m_owner[d];
    if (o < 0) return;
    if (e_hs[d]) begin
      if (d == 0 || lst[d][o]) m_left[d]--;
      m_inpkt[d] = (d == 1) && !lst[d][o];
      if (m_left[d] == 0) begin
        m_owner[d] = -1;
        m_ptr[d]   = (o + 1) % N;
      end
    end else if (!vld[d][o] && !m_inpkt[d]) begin
      m_owner[d] = -1;
      m_ptr[d]   = (o + 1) % N;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = o_valid[d];
      s_idx[d]   = o_idx[d];
      s_data[d]  = o_data[d];
      s_rdy[d]   = i_rdy[d];
      model_check(d);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_update(d);
    #1;
  endtask

  task automatic do_flush();
    flush = 2'b11;
    step();
    flush = 2'b00;
  endtask

  vec_t tv [NV];
  int   cnt [N];
  int   served [$];
  logic [1:0] h_idx;
  data_t      h_data;

  initial begin
    tv[0]  = '{3'b000, 1'b1, 1'b0, 2'd0, 3'b000};
    tv[1]  = '{3'b010, 1'b0, 1'b1, 2'd1, 3'b000};
    tv[2]  = '{3'b111, 1'b1, 1'b1, 2'd1, 3'b010};
    tv[3]  = '{3'b111, 1'b1, 1'b1, 2'd1, 3'b010};
    tv[4]  = '{3'b111, 1'b1, 1'b1, 2'd2, 3'b100};
    tv[5]  = '{3'b111, 1'b1, 1'b1, 2'd2, 3'b100};
    tv[6]  = '{3'b111, 1'b1, 1'b1, 2'd2, 3'b100};
    tv[7]  = '{3'b111, 1'b1, 1'b1, 2'd0, 3'b001};
    tv[8]  = '{3'b111, 1'b1, 1'b1, 2'd1, 3'b010};
    tv[9]  = '{3'b111, 1'b1, 1'b1, 2'd1, 3'b010};
    tv[10] = '{3'b100, 1'b1, 1'b1, 2'd2, 3'b100};
    tv[11] = '{3'b100, 1'b1, 1'b1, 2'd2, 3'b100};
    tv[12] = '{3'b100, 1'b1, 1'b1, 2'd2, 3'b100};
    tv[13] = '{3'b010, 1'b1, 1'b1, 2'd1, 3'b010};
    tv[14] = '{3'b001, 1'b1, 1'b0, 2'd1, 3'b010};
    tv[15] = '{3'b001, 1'b1, 1'b1, 2'd0, 3'b001};
    tv[16] = '{3'b000, 1'b1, 1'b0, 2'd1, 3'b000};

    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_ptr[d] = 0; m_left[d] = 0; m_inpkt[d] = 1'b0;
      for (int n = 0; n < N; n++) dat[d][n] = data_t'($urandom);
    end
    rst = 1'b1; flush = '0; ordy = '1; vld = '1; lst = '0;
    wgt = {2{{4'd1, 4'd1, 4'd1}}};

    // reset holds outputs quiet even with every input valid
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("reset valid d%0d", d), 32'(o_valid[d]), 32'd0);
        chk($sformatf("reset ready d%0d", d), 32'(i_rdy[d]), 32'd0);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("first grant valid d%0d", d), 32'(s_valid[d]), 32'd1);
      chk($sformatf("first grant idx d%0d", d), 32'(s_idx[d]), 32'd0);
    end

    // table: weights {1,2,3} on the beat-mode instance
    vld = '0;
    do_flush();
    wgt[0] = {4'd3, 4'd2, 4'd1};
    for (int i = 0; i < NV; i++) begin
      vld[0]  = tv[i].vld;
      ordy[0] = tv[i].ordy;
      step();
      chk($sformatf("tbl[%0d] valid", i), 32'(s_valid[0]), 32'(tv[i].ev));
      chk($sformatf("tbl[%0d] idx", i), 32'(s_idx[0]), 32'(tv[i].eidx));
      chk($sformatf("tbl[%0d] ready", i), 32'(s_rdy[0]), 32'(tv[i].erdy));
      if (tv[i].ev) chk($sformatf("tbl[%0d] data", i), 32'(s_data[0]), 32'(dat[0][tv[i].eidx]));
    end

    // bandwidth share over 600 beats
    do_flush();
    vld[0] = '1; ordy[0] = 1'b1;
    for (int n = 0; n < N; n++) cnt[n] = 0;
    repeat (600) begin
      step();
      if (s_valid[0]) cnt[s_idx[0]]++;
    end
    for (int n = 0; n < N; n++) chk($sformatf("share in%0d", n), 32'(cnt[n]), 32'((n + 1) * 100));

    // back-pressure: selection and data frozen, no ready
    do_flush();
    wgt[0] = {4'd2, 4'd2, 4'd2};
    ordy[0] = 1'b0;
    step();
    h_idx = s_idx[0]; h_data = s_data[0];
    chk("bp ready", 32'(s_rdy[0]), 32'd0);
    repeat (4) begin
      step();
      chk("bp idx held", 32'(s_idx[0]), 32'(h_idx));
      chk("bp data held", 32'(s_data[0]), 32'(h_data));
      chk("bp ready", 32'(s_rdy[0]), 32'd0);
    end
    ordy[0] = 1'b1;

    // packet mode: 4-beat packet with a gap is not broken by input 1
    vld[0] = '0;
    do_flush();
    wgt[1] = {4'd1, 4'd1, 4'd1};
    vld[1] = 3'b011; lst[1] = '0; ordy[1] = 1'b1;
    served.delete();
    for (int c = 0; c < 7; c++) begin
      vld[1][0] = !(c == 2 || c == 3) && (c < 6);
      lst[1][0] = (c == 5);
      step();
      if (s_valid[1]) served.push_back(int'(s_idx[1]));
      if (c == 2 || c == 3) begin
        chk("pkt gap valid", 32'(s_valid[1]), 32'd0);
        chk("pkt gap idx", 32'(s_idx[1]), 32'd0);
      end
    end
    chk("pkt beats served", 32'(served.size()), 32'd5);
    for (int i = 0; i < served.size() && i < 5; i++)
      chk($sformatf("pkt order[%0d]", i), 32'(served[i]), (i < 4) ? 32'd0 : 32'd1);
    lst[1] = '0; vld[1] = '0;

    // early release on input 2 wraps to input 0
    do_flush();
    wgt[0] = {4'd8, 4'd8, 4'd8};
    vld[0] = 3'b100;
    repeat (3) begin
      step();
      chk("early idx", 32'(s_idx[0]), 32'd2);
    end
    vld[0] = 3'b011;
    step();
    chk("early drop valid", 32'(s_valid[0]), 32'd0);
    step();
    chk("early next valid", 32'(s_valid[0]), 32'd1);
    chk("early next idx", 32'(s_idx[0]), 32'd0);

    // zero weight masks an input
    do_flush();
    wgt[0] = {4'd0, 4'd5, 4'd0};
    vld[0] = 3'b011;
    for (int n = 0; n < N; n++) cnt[n] = 0;
    repeat (20) begin
      step();
      if (s_valid[0]) cnt[s_idx[0]]++;
    end
    chk("mask in0", 32'(cnt[0]), 32'd0);
    chk("mask in1", 32'(cnt[1]), 32'd20);

    // all weights zero: nothing moves
    wgt[0] = '0; vld[0] = '1;
    repeat (4) begin
      step();
      chk("allzero valid", 32'(s_valid[0]), 32'd0);
      chk("allzero ready", 32'(s_rdy[0]), 32'd0);
    end

    // flush mid-grant clears the pointer back to 0
    do_flush();
    wgt[0] = {4'd8, 4'd8, 4'd1};
    vld[0] = '1;
    repeat (3) step();
    chk("pre-flush idx", 32'(s_idx[0]), 32'd1);
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    step();
    chk("post-flush idx", 32'(s_idx[0]), 32'd0);

    // randomized traffic, weights and flushes on both instances
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 64 == 0)
        for (int d = 0; d < 2; d++)
          for (int n = 0; n < N; n++)
            wgt[d][n] = ($urandom_range(0, 7) == 0) ? WW'($urandom) : WW'($urandom_range(0, 3));
      for (int d = 0; d < 2; d++) begin
        flush[d] = ($urandom_range(0, 49) == 0);
        ordy[d]  = ($urandom_range(0, 9) < 7);
        for (int n = 0; n < N; n++) begin
          if (!vld[d][n] || s_rdy[d][n] || cyc == 0) begin
            vld[d][n] = ($urandom_range(0, 2) != 0);
            lst[d][n] = ($urandom_range(0, 2) == 0);
            dat[d][n] = data_t'($urandom);
          end
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
